// File: rtl/plot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plot_pkg
//  Description : Shared constants, state encoding and address-map helper for
//                the speed-plot RAM scheduler.
//                COLS x ROWS 1-bit plot; row 0 is the bottom line, so the
//                linear address is (ROWS-1-row)*COLS + col.
//  Revision    : 1.0 - initial release
// ============================================================================
package plot_pkg;

    localparam int COLS  = 300;            // plot width in columns
    localparam int ROWS  = 100;            // plot height in rows
    localparam int AW    = 15;             // RAM address width
    localparam int VW    = 16;             // sample value width
    localparam int RW    = $clog2(ROWS);   // row index width
    localparam int CW    = $clog2(COLS);   // column index width
    localparam int CELLS = ROWS * COLS;    // RAM depth in bits

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_PLOT    = 3'd3,
        ST_ADVANCE = 3'd4
    } state_t;

    // Linear RAM address of (row, col); row 0 lives at the highest row base.
    function automatic logic [AW-1:0] addrMap(input logic [RW-1:0] row,
                                              input logic [CW-1:0] col);
        return AW'((ROWS - 1 - int'(row)) * COLS + int'(col));
    endfunction

endpackage
`default_nettype wire

// File: rtl/plot_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : plot_addr_gen
//  Description : Address generator for the plot sequencer.
//                - linear counter used by the power-up clear
//                - row counter with an accumulated row base (steps of -COLS)
//                - column counter wrapping at COLS-1
//                All updates are frozen while i_stall is high.
//  Ports       : clk, rst       clock / synchronous active-high reset
//                i_stall        hold every counter this cycle
//                i_linStep      advance the linear counter
//                i_rowLoad      load row counter with i_loadRow
//                i_rowStep      row counter +1 (row base -COLS)
//                i_colAdv       advance column with wrap
//                o_linAddr      linear clear address
//                o_row          current row counter
//                o_column       current column
//                o_rowAddr      address of (o_row, o_column)
//  Revision    : 1.0 - initial release
// ============================================================================
module plot_addr_gen
    import plot_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_stall,
    input  logic          i_linStep,
    input  logic          i_rowLoad,
    input  logic [RW-1:0] i_loadRow,
    input  logic          i_rowStep,
    input  logic          i_colAdv,
    output logic [AW-1:0] o_linAddr,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_column,
    output logic [AW-1:0] o_rowAddr
);

    logic [AW-1:0] r_linAddr;
    logic [RW-1:0] r_row;
    logic [AW-1:0] r_rowBase;   // (ROWS-1-r_row)*COLS, kept incrementally
    logic [CW-1:0] r_column;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_linAddr <= '0;
            r_row     <= '0;
            r_rowBase <= '0;
            r_column  <= '0;
        end else if (!i_stall) begin
            if (i_linStep) begin
                r_linAddr <= r_linAddr + 1'b1;
            end
            if (i_rowLoad) begin
                r_row     <= i_loadRow;
                r_rowBase <= addrMap(i_loadRow, '0);
            end else if (i_rowStep) begin
                // Moving up one row moves one line toward address 0.
                r_row     <= r_row + 1'b1;
                r_rowBase <= r_rowBase - AW'(COLS);
            end
            if (i_colAdv) begin
                r_column <= (r_column == CW'(COLS - 1)) ? '0 : r_column + 1'b1;
            end
        end
    end

    assign o_linAddr = r_linAddr;
    assign o_row     = r_row;
    assign o_column  = r_column;
    assign o_rowAddr = r_rowBase + AW'(r_column);

endmodule
`default_nettype wire

// File: rtl/plot_ram_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : plot_ram_scheduler
//  Description : Controller/arbiter for the single-port 1-bit speed-plot RAM.
//                The display read path always wins the RAM; the plot
//                sequencer only progresses in cycles without disp_req.
//                After reset the whole RAM is cleared; each sample tick then
//                erases the current column, plots the value and advances the
//                column (scrolling-erase strip chart).
//  Ports       : clock, reset          clock / synchronous active-high reset
//                sample_tick/value     new plot point request and value
//                disp_req/disp_addr    display read request and address
//                pix_out/pix_valid     fetched pixel (FF/00), valid flag
//                ram_addr/we/din/dout  single-port RAM interface (1-cycle read)
//                busy                  sequencer not idle
//                overrun               sticky: a sample was dropped
//  Options     : PLOT_LINE_EN - when defined, each plot draws a vertical
//                segment from the previous row to the new row so the trace
//                is connected.
//  Revision    : 1.0 - initial release
// ============================================================================
module plot_ram_scheduler
    import plot_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          sample_tick,
    input  logic [VW-1:0] sample_value,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [7:0]    pix_out,
    output logic          pix_valid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic          ram_din,
    input  logic          ram_dout,
    output logic          busy,
    output logic          overrun
);

    state_t        r_state;
    state_t        w_nextState;

    logic          r_pendValid;
    logic [RW-1:0] r_pendRow;
    logic [RW-1:0] r_plotRow;
    logic          r_overrun;
    logic          r_pixValid;

    logic [RW-1:0] w_tickRow;
    logic          w_take;
    logic [AW-1:0] w_seqAddr;
    logic          w_seqWe;
    logic          w_seqDin;
    logic          w_linStep;
    logic          w_rowLoad;
    logic [RW-1:0] w_loadRow;
    logic          w_rowStep;
    logic          w_colAdv;
    logic [RW-1:0] w_lineLo;
    logic [RW-1:0] w_lineHi;

    logic [AW-1:0] w_linAddr;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_column;
    logic [AW-1:0] w_rowAddr;

    assign w_tickRow = (sample_value > VW'(ROWS - 1)) ? RW'(ROWS - 1)
                                                      : sample_value[RW-1:0];

    plot_addr_gen u_addrGen (
        .clk       (clock),
        .rst       (reset),
        .i_stall   (disp_req),
        .i_linStep (w_linStep),
        .i_rowLoad (w_rowLoad),
        .i_loadRow (w_loadRow),
        .i_rowStep (w_rowStep),
        .i_colAdv  (w_colAdv),
        .o_linAddr (w_linAddr),
        .o_row     (w_row),
        .o_column  (w_column),
        .o_rowAddr (w_rowAddr)
    );

`ifdef PLOT_LINE_EN
    logic [RW-1:0] r_prevRow;
    logic          r_havePrev;
    logic          w_plotDone;

    assign w_plotDone = (r_state == ST_PLOT) && !disp_req && (w_row == w_lineHi);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prevRow  <= '0;
            r_havePrev <= 1'b0;
        end else if (w_plotDone) begin
            r_prevRow  <= r_plotRow;
            r_havePrev <= 1'b1;
        end
    end

    // First plot after reset has no predecessor and draws a single point.
    always_comb begin
        w_lineLo = r_plotRow;
        w_lineHi = r_plotRow;
        if (r_havePrev) begin
            if (r_prevRow < r_plotRow) begin
                w_lineLo = r_prevRow;
            end else begin
                w_lineHi = r_prevRow;
            end
        end
    end
`else
    assign w_lineLo = r_plotRow;
    assign w_lineHi = r_plotRow;
`endif

    // Next-state and sequencer request. The row counter is reused for both
    // the column erase (rows 0..ROWS-1) and the plot (rows lo..hi).
    always_comb begin
        w_nextState = r_state;
        w_seqAddr   = '0;
        w_seqWe     = 1'b0;
        w_seqDin    = 1'b0;
        w_linStep   = 1'b0;
        w_rowLoad   = 1'b0;
        w_loadRow   = '0;
        w_rowStep   = 1'b0;
        w_colAdv    = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_seqAddr = w_linAddr;
                w_seqWe   = 1'b1;
                if (w_linAddr == AW'(CELLS - 1)) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_linStep = 1'b1;
                end
            end
            ST_IDLE: begin
                if (r_pendValid || sample_tick) begin
                    w_take      = 1'b1;
                    w_rowLoad   = 1'b1;
                    w_nextState = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_seqAddr = w_rowAddr;
                w_seqWe   = 1'b1;
                if (w_row == RW'(ROWS - 1)) begin
                    w_rowLoad   = 1'b1;
                    w_loadRow   = w_lineLo;
                    w_nextState = ST_PLOT;
                end else begin
                    w_rowStep = 1'b1;
                end
            end
            ST_PLOT: begin
                w_seqAddr = w_rowAddr;
                w_seqWe   = 1'b1;
                w_seqDin  = 1'b1;
                if (w_row == w_lineHi) begin
                    w_nextState = ST_ADVANCE;
                end else begin
                    w_rowStep = 1'b1;
                end
            end
            ST_ADVANCE: begin
                w_colAdv    = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_INIT;
            end
        endcase
        // Display owns the RAM this cycle: the sequencer freezes in place.
        if (disp_req) begin
            w_nextState = r_state;
            w_take      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_pendValid <= 1'b0;
            r_pendRow   <= '0;
            r_plotRow   <= '0;
            r_overrun   <= 1'b0;
            r_pixValid  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_pixValid <= disp_req;
            if (w_take) begin
                r_plotRow <= r_pendValid ? r_pendRow : w_tickRow;
            end
            // One-deep sample buffer: a tick not consumed directly is held;
            // if the buffer is still full the tick is lost.
            if (w_take) begin
                if (r_pendValid && sample_tick) begin
                    r_pendRow <= w_tickRow;
                end else begin
                    r_pendValid <= 1'b0;
                end
            end else if (sample_tick) begin
                if (r_pendValid) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pendValid <= 1'b1;
                    r_pendRow   <= w_tickRow;
                end
            end
        end
    end

    // Arbiter: display reads take priority over sequencer writes.
    assign ram_addr = disp_req ? disp_addr : w_seqAddr;
    assign ram_we   = !disp_req && !reset && w_seqWe;
    assign ram_din  = !disp_req && w_seqDin;

    // ram_dout carries the bit addressed in the previous cycle, the same
    // cycle r_pixValid flags it, so gating here gives 1-cycle latency.
    assign pix_out   = (r_pixValid && ram_dout) ? 8'hFF : 8'h00;
    assign pix_valid = r_pixValid;
    assign busy      = (r_state != ST_IDLE);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_plot_ram_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plot_ram_scheduler
//  Description : Directed self-checking bench for plot_ram_scheduler with a
//                behavioural 1-bit RAM (1-cycle read latency). Expected
//                values follow addr = (99-row)*300 + col. Honours
//                PLOT_LINE_EN for the expected plot segment.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plot_ram_scheduler;

    logic        clock        = 1'b0;
    logic        reset        = 1'b1;
    logic        sample_tick  = 1'b0;
    logic [15:0] sample_value = '0;
    logic        disp_req     = 1'b0;
    logic [14:0] disp_addr    = '0;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic        ram_din;
    logic        ram_dout     = 1'b0;
    logic        busy;
    logic        overrun;

    int          errors       = 0;
    int          checks       = 0;
    int          modelPrev    = -1;
    int          weDuringDisp = 0;
    bit          mem [0:29999];
    logic [15:0] wq [$];

    plot_ram_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .sample_value (sample_value),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .pix_out      (pix_out),
        .pix_valid    (pix_valid),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    // RAM model plus write log.
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
        if (!reset && ram_we) wq.push_back({ram_din, ram_addr});
        if (ram_we && disp_req) weDuringDisp++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int expAddr(input int row, input int col);
        return (99 - row) * 300 + col;
    endfunction

    function automatic int loOf(input int prev, input int row);
`ifdef PLOT_LINE_EN
        if (prev >= 0 && prev < row) return prev;
`endif
        return row;
    endfunction

    function automatic int hiOf(input int prev, input int row);
`ifdef PLOT_LINE_EN
        if (prev >= 0 && prev > row) return prev;
`endif
        return row;
    endfunction

    function automatic int plotLen(input int prev, input int row);
        return hiOf(prev, row) - loOf(prev, row) + 1;
    endfunction

    // Consume one plot's writes from the log: 100 zero-writes for rows
    // 0..99 of col, then ones for rows lo..hi. 'extra' = entries that should
    // remain queued behind this plot.
    task automatic checkPlotQ(input string tag, input int col, input int row, input int extra);
        int lo, hi, need, bad;
        logic [15:0] e;
        lo   = loOf(modelPrev, row);
        hi   = hiOf(modelPrev, row);
        need = 100 + hi - lo + 1;
        bad  = 0;
        check($sformatf("%s_len", tag), wq.size(), need + extra);
        if (wq.size() >= need) begin
            for (int r = 0; r < 100; r++) begin
                e = wq.pop_front();
                if (e !== {1'b0, 15'(expAddr(r, col))}) bad++;
            end
            for (int r = lo; r <= hi; r++) begin
                e = wq.pop_front();
                if (e !== {1'b1, 15'(expAddr(r, col))}) bad++;
            end
        end else begin
            bad = need;
        end
        check($sformatf("%s_seq", tag), bad, 0);
        modelPrev = row;
    endtask

    // Tick from IDLE, wait (bounded) for busy to drop, check latency and log.
    task automatic plotOne(input string tag, input int value, input int col);
        int n, row;
        row = (value > 99) ? 99 : value;
        wq.delete();
        sample_value = 16'(value);
        sample_tick  = 1'b1;
        step();
        sample_tick  = 1'b0;
        n = 1;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        check($sformatf("%s_cycles", tag), n, 102 + plotLen(modelPrev, row));
        checkPlotQ(tag, col, row, 0);
    endtask

    initial begin
        int n, bad, extraB;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_busy", busy, 1);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_out", pix_out, 0);
        check("rst_overrun", overrun, 0);

        // ---------------- power-up clear ----------------
        reset = 1'b0;
        wq.delete();
        n = 0;
        while (busy && n < 31000) begin
            step();
            n++;
        end
        check("init_cycles", n, 30000);
        check("init_writes", wq.size(), 30000);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i] !== {1'b0, 15'(i)}) bad++;
        end
        check("init_seq", bad, 0);
        check("init_overrun", overrun, 0);

        // ---------------- single plots and clamping ----------------
        plotOne("plot40", 40, 0);       // 1 at 17700
        plotOne("clamp500", 500, 1);    // row 99 -> addr 1
        plotOne("zero", 0, 2);          // row 0 -> addr 29702

        // ---------------- display stall mid-clear ----------------
        wq.delete();
        n = 102 + plotLen(modelPrev, 40) + 50;
        sample_value = 16'd40;
        sample_tick  = 1'b1;
        step();
        sample_tick  = 1'b0;
        repeat (19) step();
        disp_req  = 1'b1;
        disp_addr = 15'd17700;
        step();
        check("rd17700_valid", pix_valid, 1);
        check("rd17700_pix", pix_out, 8'hFF);
        disp_addr = 15'd29999;
        step();
        check("rd29999_pix", pix_out, 8'h00);
        disp_addr = 15'd1;
        step();
        check("rd1_pix", pix_out, 8'hFF);
        repeat (47) step();
        disp_req = 1'b0;
        step();
        check("rd_release_valid", pix_valid, 0);
        bad = 71;
        while (busy && bad < 2000) begin
            step();
            bad++;
        end
        check("stall_cycles", bad, n);
        check("stall_no_we", weDuringDisp, 0);
        checkPlotQ("stall", 3, 40, 0);

        // ---------------- three ticks in one busy period ----------------
        wq.delete();
        extraB = 100 + plotLen(10, 20);
        sample_value = 16'd10;
        sample_tick  = 1'b1;
        step();
        sample_tick  = 1'b0;
        repeat (4) step();
        sample_value = 16'd20;
        sample_tick  = 1'b1;
        step();
        sample_tick  = 1'b0;
        repeat (4) step();
        check("ovr_before_third", overrun, 0);
        sample_value = 16'd30;
        sample_tick  = 1'b1;
        step();
        sample_tick  = 1'b0;
        check("ovr_after_third", overrun, 1);
        repeat (400) step();
        check("ovr_idle", busy, 0);
        checkPlotQ("first", 4, 10, extraB);
        checkPlotQ("pending", 5, 20, 0);

        // ---------------- scroll to wrap ----------------
        for (int c = 6; c < 300; c++) begin
            plotOne($sformatf("scroll%0d", c), (c * 7) % 100, c);
        end
        plotOne("wrap", 70, 0);
        disp_req  = 1'b1;
        disp_addr = 15'd17700;
        step();
        check("wrap_old_erased", pix_out, 8'h00);
        disp_addr = 15'd8700;
        step();
        check("wrap_new_set", pix_out, 8'hFF);
        disp_req = 1'b0;
        step();
        check("ovr_sticky", overrun, 1);

        // ---------------- reset mid-operation ----------------
        sample_value = 16'd5;
        sample_tick  = 1'b1;
        step();
        sample_tick  = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        check("rst2_busy", busy, 1);
        check("rst2_overrun", overrun, 0);
        reset = 1'b0;
        wq.delete();
        repeat (5) step();
        check("rst2_writes", wq.size(), 5);
        check("rst2_first", wq[0], 16'h0000);
        check("rst2_fifth", wq[4], 16'h0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plot_ram_scheduler.md
Name: plot_ram_scheduler

Overview:
- Controller and arbiter for the single-port 1-bit speed-plot RAM (300 columns x 100 rows, 30000 bits).
- Shares the RAM between the display read path (VGA pixel fetch) and an internal plot sequencer.
- The sequencer clears the whole RAM after reset. On each sample tick it erases the current column, plots the new speed value, then advances the column, giving a scrolling-erase strip chart.

Parameters:
- COLS, 300, plot width in pixels/columns
- ROWS, 100, plot height in rows
- AW, 15, RAM address width
- VW, 16, sample value width

Ports:
- clock  in  1  system clock; RAM clock
- reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle pulse requesting a new plot point
- sample_value  in  VW  speed value; row index, clamped to ROWS-1
- disp_req  in  1  display read request, this cycle
- disp_addr  in  AW  display read address
- pix_out  out  8  8'hFF if the fetched bit is 1, else 8'h00
- pix_valid  out  1  pix_out corresponds to the disp_req of the previous cycle
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  1  RAM write data
- ram_dout  in  1  RAM read data; 1-cycle latency
- busy  out  1  sequencer not idle
- overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset, synchronous on clock: pix_out=0, pix_valid=0, overrun=0, busy=1, column=0, pending=0, state=INIT, internal write request=0. Reset mid-operation abandons any clear or plot immediately.
- Address map: addr = (ROWS-1-row)*COLS + col. Row 0 is the bottom line. Plot values are clamped: row = min(sample_value, ROWS-1).
- Arbitration (combinational mux):
  - disp_req=1: ram_addr=disp_addr, ram_we=0.
  - Otherwise: ram_addr=seq_addr, ram_we=seq_we, ram_din=seq_din.
  - Display always wins. The sequencer stalls (holds state, counters and seq_* signals) in any cycle with disp_req=1, and may only progress during blanking.
- Display path: pix_valid <= disp_req. pix_out <= (disp_req & ram_dout_next) ? 8'hFF : 8'h00, aligned to the RAM's 1-cycle latency. Read-to-pixel latency is 1 cycle.
- State machine:
  - INIT: writes 0 to addresses 0..ROWS*COLS-1, one per granted cycle, then goes to IDLE.
  - IDLE: busy=0. If pending or sample_tick: latch row and go to CLEAR.
  - CLEAR: writes 0 to rows 0..ROWS-1 of the current column (ROWS granted cycles), then goes to PLOT.
  - PLOT: writes 1 at (row, column), 1 granted cycle, then goes to ADVANCE.
  - ADVANCE: column <= (column==COLS-1) ? 0 : column+1; goes to IDLE. No RAM access.
- Uncontended tick-to-IDLE time: ROWS+3 cycles (103 by default).
- Sample buffering:
  - A sample_tick while busy (any state except IDLE) is captured into a one-deep pending register (value + flag).
  - A tick while pending is already full is dropped and sets overrun, which stays set until reset.
  - Ticks during INIT are handled the same way.
  - A tick arriving in the same cycle ADVANCE returns to IDLE is captured as pending and served next.
- Arithmetic: address computed in AW bits; ROWS*COLS-1 must fit AW. The column counter wraps exactly at COLS-1. The row multiply may be a per-row accumulator (+COLS steps) rather than a multiplier.

Optional Feature:
- Macro: PLOT_LINE_EN.
- Defined: PLOT writes 1 at every row from min(prev_row,row) to max(prev_row,row) inclusive, taking |row-prev_row|+1 granted cycles, to draw a connected trace. prev_row is updated after PLOT and retained across column wrap. The first plot after reset draws a single point.
- Undefined: PLOT writes a single point, as described in Behaviour, and prev_row logic is absent.

Decomposition:
- Package plot_pkg: COLS, ROWS, AW, VW constants; a state enum (INIT, IDLE, CLEAR, PLOT, ADVANCE); a function for the address map.
- One natural sub-module, plot_addr_gen: row/column counters and the accumulated address, with stall input.
- The arbiter mux and FSM stay in the top module.

Test Plan:
- Reset, no disp_req: exactly 30000 writes of 0 to addresses 0..29999 -> busy falls at cycle 30000 (+1), overrun=0.
- After INIT, sample_tick with value 40, column 0 -> 100 zero-writes to col 0, then one write of 1 at addr 59*300+0=17700; column becomes 1; busy low 103 cycles after tick.
- sample_value 500 -> clamped to row 99, write at addr 0+col. Value 0 -> addr 29700+col.
- disp_req held high for 50 cycles mid-CLEAR -> no ram_we during those cycles, clear resumes at the stalled row, pix_valid follows disp_req by 1 cycle, pix_out=FF for stored 1s.
- Three ticks during one busy period -> first served, second pending, third dropped, overrun=1 until reset. After 300 plots the column wraps to 0 and the old column-0 trace is erased before replot.
- PLOT_LINE_EN defined, samples 10 then 20 -> second column writes rows 10..20 (11 writes of 1); without the macro, a single write at row 20.
